// File: rtl/vc_fifo.sv
// ---------------------------------------------------------------------------
// vc_fifo - multi-virtual-channel router input buffer.
//
// Holds NUM_VC independent circular queues of DEPTH flits each, kept in one
// two-dimensional storage array. Each cycle one write and one read may be
// issued, each naming its own VC. The read path is first-word-fall-through:
// odata always shows the head flit of VC rd_vc, or 0 when that VC is empty.
//
// Parameters:
//   DATAW  - flit width in bits
//   DEPTH  - flits per VC (>= 2, need not be a power of two)
//   NUM_VC - number of virtual channels (>= 1)
//   PKTLEN - flits per packet, used for ordy (1 <= PKTLEN <= DEPTH)
//   VCW    - VC select width (derived)
//   CNTW   - occupancy counter width (derived)
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   rst_     - synchronous reset, active-high; clears pointers and counts
//   idata    - write flit
//   wr_en    - write request
//   wr_vc    - target VC of the write
//   rd_en    - read request
//   rd_vc    - source VC of the read; also selects odata
//   odata    - head flit of VC rd_vc, 0 when that VC is empty
//   empty    - bit v set when VC v holds no flits
//   full     - bit v set when VC v holds DEPTH flits
//   ordy     - bit v set when VC v has room for a whole packet
//   cnt_flat - per-VC occupancy, VC v in bits [v*CNTW +: CNTW]
//   err      - (only with VC_FIFO_ERR_EN) sticky {underflow, overflow}
//
// Optional feature: define VC_FIFO_ERR_EN to add the sticky err output.
// ---------------------------------------------------------------------------
module vc_fifo #(
    parameter int  DATAW  = 32,
    parameter int  DEPTH  = 4,
    parameter int  NUM_VC = 2,
    parameter int  PKTLEN = 4,
    localparam int VCW    = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    localparam int CNTW   = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic [DATAW-1:0]       idata,
    input  logic                   wr_en,
    input  logic [VCW-1:0]         wr_vc,
    input  logic                   rd_en,
    input  logic [VCW-1:0]         rd_vc,
    output logic [DATAW-1:0]       odata,
    output logic [NUM_VC-1:0]      empty,
    output logic [NUM_VC-1:0]      full,
    output logic [NUM_VC-1:0]      ordy,
    output logic [NUM_VC*CNTW-1:0] cnt_flat
`ifdef VC_FIFO_ERR_EN
    ,
    output logic [1:0]             err
`endif
);

    localparam int              PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0]   PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);
    localparam logic [CNTW-1:0] CNT_PKT  = CNTW'(PKTLEN);

    // Flit storage; deliberately not reset.
    logic [DATAW-1:0] mem_q [NUM_VC][DEPTH];

    logic [PW-1:0]    wr_ptr_q [NUM_VC];
    logic [PW-1:0]    wr_ptr_d [NUM_VC];
    logic [PW-1:0]    rd_ptr_q [NUM_VC];
    logic [PW-1:0]    rd_ptr_d [NUM_VC];
    logic [CNTW-1:0]  cnt_q    [NUM_VC];
    logic [CNTW-1:0]  cnt_d    [NUM_VC];

    logic [NUM_VC-1:0] wr_hit;
    logic [NUM_VC-1:0] rd_hit;

    // Values of the VCs named by wr_vc / rd_vc. An out-of-range VC matches
    // nothing, so it looks invalid and empty and its request is dropped.
    logic              wr_vc_ok;
    logic              wr_full_sel;
    logic [PW-1:0]     wr_ptr_sel;
    logic              rd_empty_sel;
    logic [PW-1:0]     rd_ptr_sel;

    logic              rd_ok;
    logic              wr_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        // Explicit wrap so DEPTH need not be a power of two.
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Per-VC status flags and flattened occupancy
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
            assign empty[gi] = (cnt_q[gi] == '0);
            assign full[gi]  = (cnt_q[gi] == CNT_FULL);
            // cnt never exceeds DEPTH, so the subtraction cannot wrap.
            assign ordy[gi]  = ((CNT_FULL - cnt_q[gi]) >= CNT_PKT);
            assign cnt_flat[gi*CNTW +: CNTW] = cnt_q[gi];
            assign wr_hit[gi] = wr_ok & (wr_vc == VCW'(gi));
            assign rd_hit[gi] = rd_ok & (rd_vc == VCW'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Select the state of the addressed VCs
    // ------------------------------------------------------------------
    always_comb begin
        wr_vc_ok     = 1'b0;
        wr_full_sel  = 1'b0;
        wr_ptr_sel   = '0;
        rd_empty_sel = 1'b1;
        rd_ptr_sel   = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (wr_vc == VCW'(v)) begin
                wr_vc_ok    = 1'b1;
                wr_full_sel = full[v];
                wr_ptr_sel  = wr_ptr_q[v];
            end
            if (rd_vc == VCW'(v)) begin
                rd_empty_sel = empty[v];
                rd_ptr_sel   = rd_ptr_q[v];
            end
        end
    end

    assign rd_ok = rd_en & ~rd_empty_sel;
    // A full VC still accepts a write when the same cycle drains it.
    assign wr_ok = wr_en & wr_vc_ok &
                   (~wr_full_sel | (rd_ok & (rd_vc == wr_vc)));

    // Zero-latency head read; no write-to-read bypass, so a flit written
    // this cycle appears only after the edge.
    assign odata = rd_empty_sel ? '0 : mem_q[rd_vc][rd_ptr_sel];

    // ------------------------------------------------------------------
    // Next-state for pointers and counts
    // ------------------------------------------------------------------
    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            wr_ptr_d[v] = wr_hit[v] ? ptr_inc(wr_ptr_q[v]) : wr_ptr_q[v];
            rd_ptr_d[v] = rd_hit[v] ? ptr_inc(rd_ptr_q[v]) : rd_ptr_q[v];
            case ({wr_hit[v], rd_hit[v]})
                2'b10:   cnt_d[v] = cnt_q[v] + 1'b1;
                2'b01:   cnt_d[v] = cnt_q[v] - 1'b1;
                default: cnt_d[v] = cnt_q[v];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
                cnt_q[v]    <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr_q[v] <= wr_ptr_d[v];
                rd_ptr_q[v] <= rd_ptr_d[v];
                cnt_q[v]    <= cnt_d[v];
            end
        end
    end

    // Storage write; wr_ok guarantees wr_vc is in range.
    always_ff @(posedge clk) begin
        if (!rst_ && wr_ok) begin
            mem_q[wr_vc][wr_ptr_sel] <= idata;
        end
    end

`ifdef VC_FIFO_ERR_EN
    // ------------------------------------------------------------------
    // Sticky error flags: [0] dropped write, [1] dropped read
    // ------------------------------------------------------------------
    logic [1:0] err_q;
    logic [1:0] err_d;

    always_comb begin
        err_d = err_q | {rd_en & ~rd_ok, wr_en & ~wr_ok};
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_vc_fifo.sv
// ---------------------------------------------------------------------------
// tb_vc_fifo - self-checking bench for vc_fifo (default parameters).
// A directed vector table covers the listed corner cases, then a random
// phase is checked against per-VC queue models.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vc_fifo;

    localparam int DATAW  = 32;
    localparam int DEPTH  = 4;
    localparam int NUM_VC = 2;
    localparam int PKTLEN = 4;
    localparam int CNTW   = 3;

    logic                   clk = 1'b0;
    logic                   rst_;
    logic [DATAW-1:0]       idata;
    logic                   wr_en;
    logic [0:0]             wr_vc;
    logic                   rd_en;
    logic [0:0]             rd_vc;
    logic [DATAW-1:0]       odata;
    logic [NUM_VC-1:0]      empty;
    logic [NUM_VC-1:0]      full;
    logic [NUM_VC-1:0]      ordy;
    logic [NUM_VC*CNTW-1:0] cnt_flat;
`ifdef VC_FIFO_ERR_EN
    logic [1:0]             err;
`endif

    always #5 clk = ~clk;

    vc_fifo #(
        .DATAW  (DATAW),
        .DEPTH  (DEPTH),
        .NUM_VC (NUM_VC),
        .PKTLEN (PKTLEN)
    ) dut (
        .clk      (clk),
        .rst_     (rst_),
        .idata    (idata),
        .wr_en    (wr_en),
        .wr_vc    (wr_vc),
        .rd_en    (rd_en),
        .rd_vc    (rd_vc),
        .odata    (odata),
        .empty    (empty),
        .full     (full),
        .ordy     (ordy),
        .cnt_flat (cnt_flat)
`ifdef VC_FIFO_ERR_EN
        ,
        .err      (err)
`endif
    );

    typedef struct {
        bit          rst;
        bit          we;
        bit          wvc;
        logic [31:0] id;
        bit          re;
        bit          rvc;
        bit          chk;   // compare odata before the edge
        logic [31:0] od;    // odata expected before the edge
        int          c0;    // VC0 count after the edge
        int          c1;    // VC1 count after the edge
        logic [1:0]  e;     // err expected after the edge
    } vec_t;

    vec_t tv[$];

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input bit r, input bit we, input bit wvc, input logic [31:0] id,
                       input bit re, input bit rvc, input bit chk, input logic [31:0] od,
                       input int c0, input int c1, input logic [1:0] e);
        vec_t t;
        t.rst = r; t.we = we; t.wvc = wvc; t.id = id; t.re = re; t.rvc = rvc;
        t.chk = chk; t.od = od; t.c0 = c0; t.c1 = c1; t.e = e;
        tv.push_back(t);
    endtask

    task automatic drive(input bit r, input bit we, input bit wvc, input logic [31:0] id,
                         input bit re, input bit rvc);
        rst_  = r;
        wr_en = we;
        wr_vc = wvc;
        idata = id;
        rd_en = re;
        rd_vc = rvc;
    endtask

    // Compare status outputs against per-VC occupancies derived from the rules.
    task automatic check_status(input string tag, input int c0, input int c1);
        logic [5:0] ec;
        logic [1:0] ee, ef, eo;
        ec = {3'(c1), 3'(c0)};
        ee = {c1 == 0, c0 == 0};
        ef = {c1 == DEPTH, c0 == DEPTH};
        eo = {(DEPTH - c1) >= PKTLEN, (DEPTH - c0) >= PKTLEN};
        check({tag, " cnt_flat"}, 64'(cnt_flat), 64'(ec));
        check({tag, " empty"},    64'(empty),    64'(ee));
        check({tag, " full"},     64'(full),     64'(ef));
        check({tag, " ordy"},     64'(ordy),     64'(eo));
    endtask

    logic [31:0] q [NUM_VC][$];
    logic [1:0]  m_err;

    initial begin
        // rst we wvc idata re rvc chk odata c0 c1 err
        add(1, 0, 0, 32'h0,  0, 0, 0, 32'h0,  0, 0, 2'b00); // reset, 2 cycles
        add(1, 0, 0, 32'h0,  0, 0, 1, 32'h0,  0, 0, 2'b00);
        add(0, 1, 0, 32'hA0, 0, 0, 1, 32'h0,  1, 0, 2'b00); // fill VC0
        add(0, 1, 0, 32'hA1, 0, 0, 1, 32'hA0, 2, 0, 2'b00);
        add(0, 1, 0, 32'hA2, 0, 0, 1, 32'hA0, 3, 0, 2'b00);
        add(0, 1, 0, 32'hA3, 0, 0, 1, 32'hA0, 4, 0, 2'b00);
        add(0, 1, 0, 32'hA4, 0, 0, 1, 32'hA0, 4, 0, 2'b01); // write to full dropped
        add(0, 0, 0, 32'h0,  1, 0, 1, 32'hA0, 3, 0, 2'b01); // drain in order
        add(0, 0, 0, 32'h0,  1, 0, 1, 32'hA1, 2, 0, 2'b01);
        add(0, 0, 0, 32'h0,  1, 0, 1, 32'hA2, 1, 0, 2'b01);
        add(0, 0, 0, 32'h0,  1, 0, 1, 32'hA3, 0, 0, 2'b01);
        add(0, 0, 0, 32'h0,  1, 0, 1, 32'h0,  0, 0, 2'b11); // read of empty dropped
        add(0, 1, 0, 32'hA0, 0, 0, 1, 32'h0,  1, 0, 2'b11); // refill VC0
        add(0, 1, 0, 32'hA1, 0, 0, 1, 32'hA0, 2, 0, 2'b11);
        add(0, 1, 0, 32'hA2, 0, 0, 1, 32'hA0, 3, 0, 2'b11);
        add(0, 1, 0, 32'hA3, 0, 0, 1, 32'hA0, 4, 0, 2'b11);
        add(0, 1, 0, 32'hB0, 1, 0, 1, 32'hA0, 4, 0, 2'b11); // write+read on full
        add(0, 0, 0, 32'h0,  1, 0, 1, 32'hA1, 3, 0, 2'b11);
        add(0, 0, 0, 32'h0,  1, 0, 1, 32'hA2, 2, 0, 2'b11);
        add(0, 0, 0, 32'h0,  1, 0, 1, 32'hA3, 1, 0, 2'b11);
        add(0, 0, 0, 32'h0,  1, 0, 1, 32'hB0, 0, 0, 2'b11); // wrapped slot
        add(0, 1, 0, 32'hE0, 0, 0, 1, 32'h0,  1, 0, 2'b11);
        add(0, 1, 0, 32'hE1, 0, 0, 1, 32'hE0, 2, 0, 2'b11);
        add(0, 1, 1, 32'hC0, 1, 0, 1, 32'hE0, 1, 1, 2'b11); // write VC1, read VC0
        add(0, 0, 0, 32'h0,  0, 1, 1, 32'hC0, 1, 1, 2'b11);
        add(0, 0, 0, 32'h0,  1, 1, 1, 32'hC0, 1, 0, 2'b11);
        add(0, 1, 1, 32'hD0, 1, 1, 1, 32'h0,  1, 1, 2'b11); // same-VC on empty
        add(0, 0, 0, 32'h0,  0, 1, 1, 32'hD0, 1, 1, 2'b11);
        add(0, 1, 0, 32'hF0, 0, 0, 1, 32'hE1, 2, 1, 2'b11);
        add(0, 1, 0, 32'hF1, 0, 0, 1, 32'hE1, 3, 1, 2'b11);
        add(0, 1, 1, 32'hF2, 0, 0, 1, 32'hE1, 3, 2, 2'b11);
        add(1, 1, 0, 32'hF3, 1, 0, 1, 32'hE1, 0, 0, 2'b00); // reset mid-traffic
        add(0, 0, 0, 32'h0,  0, 0, 1, 32'h0,  0, 0, 2'b00);

        drive(1, 0, 0, 32'h0, 0, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].rst, tv[i].we, tv[i].wvc, tv[i].id, tv[i].re, tv[i].rvc);
            @(negedge clk);
            if (tv[i].chk)
                check($sformatf("vec%0d odata", i), 64'(odata), 64'(tv[i].od));
            @(posedge clk);
            #1;
            check_status($sformatf("vec%0d", i), tv[i].c0, tv[i].c1);
`ifdef VC_FIFO_ERR_EN
            check($sformatf("vec%0d err", i), 64'(err), 64'(tv[i].e));
`endif
            $display("vec%0d rst=%0d we=%0d/%0d id=%0h re=%0d/%0d odata=%0h cnt=%0h",
                     i, tv[i].rst, tv[i].we, tv[i].wvc, tv[i].id, tv[i].re, tv[i].rvc,
                     odata, cnt_flat);
        end

        // Random phase against per-VC queues; the table ends freshly reset.
        m_err = 2'b00;
        for (int k = 0; k < 600; k++) begin
            bit          r, we, wvc, re, rvc, rd_ok, wr_ok;
            logic [31:0] id, exp_od;
            int          wp;
            wp  = ((k / 50) % 2 == 0) ? 75 : 35;
            r   = ($urandom_range(0, 99) < 2);
            we  = ($urandom_range(0, 99) < wp);
            wvc = 1'($urandom_range(0, 1));
            id  = $urandom;
            re  = ($urandom_range(0, 99) < 50);
            rvc = 1'($urandom_range(0, 1));
            drive(r, we, wvc, id, re, rvc);
            @(negedge clk);
            exp_od = (q[rvc].size() != 0) ? q[rvc][0] : 32'h0;
            check($sformatf("rnd%0d odata", k), 64'(odata), 64'(exp_od));
            if (r) begin
                q[0].delete();
                q[1].delete();
                m_err = 2'b00;
            end else begin
                rd_ok = re && (q[rvc].size() > 0);
                wr_ok = we && ((q[wvc].size() < DEPTH) || (rd_ok && rvc == wvc));
                if (rd_ok) void'(q[rvc].pop_front());
                if (wr_ok) q[wvc].push_back(id);
                m_err = m_err | {re && !rd_ok, we && !wr_ok};
            end
            @(posedge clk);
            #1;
            check_status($sformatf("rnd%0d", k), q[0].size(), q[1].size());
`ifdef VC_FIFO_ERR_EN
            check($sformatf("rnd%0d err", k), 64'(err), 64'(m_err));
`endif
            $display("rnd%0d rst=%0d we=%0d/%0d re=%0d/%0d odata=%0h cnt=%0h",
                     k, r, we, wvc, re, rvc, exp_od, cnt_flat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/vc_fifo.md
Name: vc_fifo

Overview:
Parametrised multi-virtual-channel router input buffer, successor to the single-queue router FIFO. It holds NUM_VC independent circular queues of DEPTH flits each in one storage array. Writes and reads each name a VC. Per-VC empty, full and packet-space-ready vectors drive upstream credit and the switch allocator.

Parameters:
DATAW, 32, flit width in bits
DEPTH, 4, flits per VC; any integer >= 2, not required to be a power of two
NUM_VC, 2, number of virtual channels; >= 1
PKTLEN, 4, flits per packet; used by ordy; 1 <= PKTLEN <= DEPTH
VCW, max(1,clog2(NUM_VC)), VC select width (derived)
CNTW, clog2(DEPTH+1), occupancy counter width (derived)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_  in  1  synchronous reset, active-high (1 = reset)
idata  in  DATAW  write flit
wr_en  in  1  write request
wr_vc  in  VCW  target VC of the write
rd_en  in  1  read request
rd_vc  in  VCW  source VC of the read; also selects odata
odata  out  DATAW  head flit of VC rd_vc; 0 when that VC is empty
empty  out  NUM_VC  bit v = VC v holds 0 flits
full  out  NUM_VC  bit v = VC v holds DEPTH flits
ordy  out  NUM_VC  bit v = VC v has room for a whole packet
cnt_flat  out  NUM_VC*CNTW  per-VC occupancy; VC v in bits [v*CNTW +: CNTW]

Behaviour:
- Per-VC state: wr_ptr, rd_ptr (0..DEPTH-1) and cnt (0..DEPTH).
- Reset: all pointers and counts are 0, so empty = all 1s, full = 0, ordy = all 1s and odata = 0. Storage is not reset.
- Reset has priority over every request. Reset asserted mid-traffic discards all queued flits in the next cycle.
- rd_ok = rd_en & ~empty[rd_vc].
- wr_ok = wr_en & (~full[wr_vc] | (rd_ok & rd_vc == wr_vc)). A write to a full VC is accepted only when the same cycle also reads that VC.
- A dropped request (write to full without a same-VC read, or read from empty) changes no state.
- Pointer wrap: a pointer at DEPTH-1 advances to 0, otherwise it increments by 1.
- On wr_ok: mem[wr_vc][wr_ptr] <= idata and wr_ptr[wr_vc] advances.
- On rd_ok: rd_ptr[rd_vc] advances.
- Count update for each VC v:
  - +1 if written and not read this cycle
  - -1 if read and not written this cycle
  - unchanged if both or neither
  - Different VCs may be written and read in the same cycle, and each count updates independently.
- Read path is combinational with zero latency: odata = empty[rd_vc] ? 0 : mem[rd_vc][rd_ptr[rd_vc]]. Data is first-word-fall-through.
- Write-to-read latency is one cycle: a flit written at edge N is visible on odata after edge N.
- Same-VC read and write when the VC is empty: the read is dropped and the write is accepted, leaving cnt = 1. There is no bypass path.
- empty, full and ordy are purely combinational from cnt: ordy[v] = (DEPTH - cnt[v]) >= PKTLEN.
- An out-of-range wr_vc or rd_vc (>= NUM_VC) is treated as a dropped request, and odata is 0.

Optional Feature:
Macro VC_FIFO_ERR_EN.
- When defined, an extra output err (2 bits) is present:
  - err[0] is sticky overflow: set by wr_en with wr_ok = 0.
  - err[1] is sticky underflow: set by rd_en with rd_ok = 0.
  - Both bits are cleared only by rst_ and reset to 0.
- When not defined, the port is absent and no error logic is built. All other behaviour is identical.

Test Plan:
- Defaults, reset asserted for 2 cycles -> empty = 2'b11, full = 2'b00, ordy = 2'b11, odata = 0, cnt_flat = 0.
- Write 0xA0..0xA3 to VC0 on 4 consecutive cycles -> full[0] = 1, ordy[0] = 0 after the first write, empty[1] = 1. A 5th write is dropped; with VC_FIFO_ERR_EN, err[0] = 1. Reads then return 0xA0..0xA3 in order, then odata = 0.
- VC0 full, then simultaneous write 0xB0 and read of VC0 -> odata = 0xA0 in that cycle and cnt stays 4. After 0xA1..0xA3 drain, 0xB0 emerges, proving the pointer wrap.
- Interleaving: write VC1 0xC0 while reading VC0 in the same cycle -> cnt[VC0] -1 and cnt[VC1] +1. odata with rd_vc = 1 shows 0xC0.
- Same-VC write and read on an empty VC1 with idata = 0xD0 -> read dropped, cnt[VC1] = 1. odata = 0xD0 the next cycle; with VC_FIFO_ERR_EN, err[1] = 1.
- Reset asserted while VC0 holds 3 flits and VC1 holds 2 -> the next cycle shows all counts 0, empty = 2'b11 and odata = 0.
